// File: rtl/pic_common_pkg.sv
// Shared types and constants for the 8259A interrupt-acknowledge initiator.
package pic_common_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PULSE_LOW  = 2'd1,
    PULSE_HIGH = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam logic [7:0] CALL_OPCODE  = 8'hCD;
  localparam logic [1:0] PULSES_8086  = 2'd2;
  localparam logic [1:0] PULSES_MCS80 = 2'd3;

endpackage

// File: rtl/inta_pulse_timer.sv
// Loadable down-counter timing the INTA# low and high phases.
module inta_pulse_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             terminal_count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // A phase of N cycles is loaded with N-1, so zero marks its final cycle.
  assign terminal_count = (count_reg == '0);

endmodule

// File: rtl/interrupt_acknowledge_master.sv
// CPU-side INTA# pulse generator: runs the 2- or 3-pulse acknowledge sequence,
// collects the bytes from the controller and hands them over with valid/ready.
module interrupt_acknowledge_master
  import pic_common_pkg::*;
#(
  parameter int PULSE_LOW_CYCLES  = 2,
  parameter int PULSE_HIGH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        interrupt_enable,
  input  logic        mcs80_mode,
  input  logic        interrupt_request,
  output logic        interrupt_acknowledge_n,
  input  logic [7:0]  data_bus_in,
  output logic        vector_valid,
  input  logic        vector_ready,
  output logic [7:0]  vector,
  output logic [15:0] call_address,
  output logic        opcode_error,
  output logic        busy
);

  localparam int MAX_CYCLES = (PULSE_LOW_CYCLES > PULSE_HIGH_CYCLES) ?
                              PULSE_LOW_CYCLES : PULSE_HIGH_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(PULSE_LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(PULSE_HIGH_CYCLES - 1);

  state_t         state_reg;
  logic           mode_reg;
  logic [1:0]     pulse_count_reg;
  logic           start;
  logic           last_pulse;
  logic           timer_tc;
  logic           timer_load;
  logic [CW-1:0]  timer_value;

  assign start      = (state_reg == IDLE) && interrupt_request && interrupt_enable;
  assign last_pulse = (pulse_count_reg == ((mode_reg ? PULSES_MCS80 : PULSES_8086) - 2'd1));

  always_comb begin
    timer_load  = 1'b0;
    timer_value = LOW_LOAD;
    case (state_reg)
      IDLE:       timer_load = start;
      PULSE_LOW:  begin
        timer_load  = timer_tc && !last_pulse;
        timer_value = HIGH_LOAD;
      end
      PULSE_HIGH: timer_load = timer_tc;
      default:    timer_load = 1'b0;
    endcase
  end

  inta_pulse_timer #(.WIDTH(CW)) u_timer (
    .clock          (clock),
    .reset          (reset),
    .load           (timer_load),
    .load_value     (timer_value),
    .terminal_count (timer_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg               <= IDLE;
      mode_reg                <= 1'b0;
      pulse_count_reg         <= 2'd0;
      interrupt_acknowledge_n <= 1'b1;
      vector_valid            <= 1'b0;
      busy                    <= 1'b0;
      opcode_error            <= 1'b0;
      vector                  <= 8'h00;
      call_address            <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg               <= PULSE_LOW;
            mode_reg                <= mcs80_mode;
            pulse_count_reg         <= 2'd0;
            interrupt_acknowledge_n <= 1'b0;
            busy                    <= 1'b1;
            opcode_error            <= 1'b0;
          end
        end
        PULSE_LOW: begin
          if (timer_tc) begin
            // Bus is captured on the edge that raises INTA#.
            interrupt_acknowledge_n <= 1'b1;
            case (pulse_count_reg)
              2'd0: if (mode_reg) opcode_error <= (data_bus_in != CALL_OPCODE);
              2'd1: begin
                if (mode_reg) call_address[7:0] <= data_bus_in;
                else          vector            <= data_bus_in;
              end
              default: if (mode_reg) call_address[15:8] <= data_bus_in;
            endcase
            if (last_pulse) begin
              state_reg    <= DONE;
              vector_valid <= 1'b1;
            end else begin
              state_reg <= PULSE_HIGH;
            end
          end
        end
        PULSE_HIGH: begin
          if (timer_tc) begin
            state_reg               <= PULSE_LOW;
            interrupt_acknowledge_n <= 1'b0;
            if (pulse_count_reg != 2'd3) pulse_count_reg <= pulse_count_reg + 2'd1;
          end
        end
        DONE: begin
          if (vector_ready) begin
            state_reg    <= IDLE;
            vector_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_acknowledge_master.sv
// Directed per-cycle vector table plus hand-written backpressure/reset sequences.
module tb_interrupt_acknowledge_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        interrupt_enable;
  logic        mcs80_mode;
  logic        interrupt_request;
  logic        interrupt_acknowledge_n;
  logic [7:0]  data_bus_in;
  logic        vector_valid;
  logic        vector_ready;
  logic [7:0]  vector;
  logic [15:0] call_address;
  logic        opcode_error;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  interrupt_acknowledge_master #(
    .PULSE_LOW_CYCLES  (2),
    .PULSE_HIGH_CYCLES (2)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .interrupt_enable        (interrupt_enable),
    .mcs80_mode              (mcs80_mode),
    .interrupt_request       (interrupt_request),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .data_bus_in             (data_bus_in),
    .vector_valid            (vector_valid),
    .vector_ready            (vector_ready),
    .vector                  (vector),
    .call_address            (call_address),
    .opcode_error            (opcode_error),
    .busy                    (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        intr, ie, mode;
    logic [7:0]  bus;
    logic        ready;
    logic        inta_n, valid, bsy;
    logic        chk;
    logic [7:0]  vec;
    logic [15:0] call;
    logic        err;
  } row_t;

  row_t tbl[$];

  function automatic row_t r(input logic intr, input logic ie, input logic mode,
                             input logic [7:0] bus, input logic ready,
                             input logic inta_n, input logic valid, input logic bsy,
                             input logic chk, input logic [7:0] vec,
                             input logic [15:0] call, input logic err);
    row_t x;
    x.intr = intr; x.ie = ie; x.mode = mode; x.bus = bus; x.ready = ready;
    x.inta_n = inta_n; x.valid = valid; x.bsy = bsy;
    x.chk = chk; x.vec = vec; x.call = call; x.err = err;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the middle of the next cycle and drive that cycle's inputs.
  task automatic cyc(input logic intr, input logic ie, input logic mode,
                     input logic [7:0] bus, input logic ready, input logic rst);
    @(negedge clock);
    interrupt_request = intr;
    interrupt_enable  = ie;
    mcs80_mode        = mode;
    data_bus_in       = bus;
    vector_ready      = ready;
    reset             = rst;
  endtask

  initial begin
    reset = 1'b1; interrupt_enable = 1'b0; mcs80_mode = 1'b0;
    interrupt_request = 1'b0; data_bus_in = 8'h00; vector_ready = 1'b0;

    // 8086: pulse-1 byte 11 discarded, vector 4A; mode toggled mid-sequence
    tbl.push_back(r(1,1,0,8'h00,0, 1,0,0, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,0,8'h00,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,0,8'h11,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'h00,0, 1,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'h00,0, 1,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'h00,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'h4A,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(0,1,0,8'h00,1, 1,1,1, 1,8'h4A,16'h0000,0));
    tbl.push_back(r(0,1,0,8'h00,0, 1,0,0, 1,8'h4A,16'h0000,0));
    // MCS-80: CD 34 12 -> 1234, no opcode error; mode dropped mid-sequence
    tbl.push_back(r(1,1,1,8'h00,0, 1,0,0, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'h00,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'hCD,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,0,8'h00,0, 1,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,0,8'h00,0, 1,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,0,8'h00,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,0,8'h34,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,0,8'h00,0, 1,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,0,8'h00,0, 1,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,0,8'h00,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,0,8'h12,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(0,1,0,8'h00,1, 1,1,1, 1,8'h4A,16'h1234,0));
    tbl.push_back(r(0,1,0,8'h00,0, 1,0,0, 1,8'h4A,16'h1234,0));
    // MCS-80: 00 56 78 -> 7856 with opcode error
    tbl.push_back(r(1,1,1,8'hFF,0, 1,0,0, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'hFF,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'h00,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'hFF,0, 1,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'hFF,0, 1,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'hFF,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'h56,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'hFF,0, 1,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'hFF,0, 1,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'hFF,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,1,8'h78,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(0,1,1,8'hFF,1, 1,1,1, 1,8'h4A,16'h7856,1));
    tbl.push_back(r(0,1,1,8'hFF,0, 1,0,0, 1,8'h4A,16'h7856,0));
    // IF gating, IF rise starts same cycle, INTR dropped after pulse 1 -> 0F
    tbl.push_back(r(1,0,0,8'h00,0, 1,0,0, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,0,0,8'h00,0, 1,0,0, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,0,0,8'h00,0, 1,0,0, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,0,8'h00,0, 1,0,0, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,0,8'h00,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(1,1,0,8'hAA,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(0,1,0,8'h00,0, 1,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(0,1,0,8'h00,0, 1,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(0,1,0,8'h00,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(0,1,0,8'h0F,0, 0,0,1, 0,8'h00,16'h0000,0));
    tbl.push_back(r(0,1,0,8'h00,1, 1,1,1, 1,8'h0F,16'h7856,0));
    tbl.push_back(r(0,1,0,8'h00,0, 1,0,0, 1,8'h0F,16'h7856,0));

    repeat (2) @(negedge clock);
    check("reset inta_n", interrupt_acknowledge_n, 1'b1);
    check("reset valid", vector_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset vector", vector, 8'h00);
    check("reset call", call_address, 16'h0000);
    check("reset err", opcode_error, 1'b0);

    foreach (tbl[i]) begin
      cyc(tbl[i].intr, tbl[i].ie, tbl[i].mode, tbl[i].bus, tbl[i].ready, 1'b0);
      check($sformatf("row%0d inta_n", i), interrupt_acknowledge_n, tbl[i].inta_n);
      check($sformatf("row%0d valid", i), vector_valid, tbl[i].valid);
      check($sformatf("row%0d busy", i), busy, tbl[i].bsy);
      if (tbl[i].chk) begin
        check($sformatf("row%0d vector", i), vector, tbl[i].vec);
        check($sformatf("row%0d call", i), call_address, tbl[i].call);
        if (tbl[i].valid) check($sformatf("row%0d err", i), opcode_error, tbl[i].err);
      end
      $display("[TB] row %0d intr=%0d ie=%0d inta_n=%0d valid=%0d busy=%0d vector=%02h call=%04h",
               i, tbl[i].intr, tbl[i].ie, interrupt_acknowledge_n, vector_valid, busy,
               vector, call_address);
    end

    // Backpressure with INTR held: cycle 0 here, valid from cycle 7
    for (int c = 0; c <= 6; c++) cyc(1, 1, 0, 8'h5A, 0, 0);
    for (int c = 7; c <= 11; c++) begin
      cyc(1, 1, 0, 8'h5A, 0, 0);
      check($sformatf("bp c%0d valid", c), vector_valid, 1'b1);
      check($sformatf("bp c%0d vector", c), vector, 8'h5A);
      check($sformatf("bp c%0d inta_n", c), interrupt_acknowledge_n, 1'b1);
    end
    cyc(1, 1, 0, 8'h5A, 1, 0);
    check("bp accept valid", vector_valid, 1'b1);
    cyc(1, 1, 0, 8'h5A, 0, 0);
    check("b2b idle valid", vector_valid, 1'b0);
    check("b2b idle busy", busy, 1'b0);
    check("b2b idle inta_n", interrupt_acknowledge_n, 1'b1);
    cyc(1, 1, 0, 8'h5A, 0, 0);
    check("b2b start inta_n", interrupt_acknowledge_n, 1'b0);
    check("b2b start busy", busy, 1'b1);
    $display("[TB] backpressure + back-to-back sequence done");

    // New sequence began at cycle 13; its pulse 2 is low on cycles 18-19
    for (int c = 15; c <= 17; c++) cyc(1, 1, 0, 8'h5A, 0, 0);
    cyc(1, 1, 0, 8'h5A, 0, 1);
    check("rst mid-pulse inta_n", interrupt_acknowledge_n, 1'b0);
    cyc(0, 1, 0, 8'h5A, 0, 0);
    check("post-rst inta_n", interrupt_acknowledge_n, 1'b1);
    check("post-rst valid", vector_valid, 1'b0);
    check("post-rst busy", busy, 1'b0);
    check("post-rst vector", vector, 8'h00);
    check("post-rst call", call_address, 16'h0000);
    check("post-rst err", opcode_error, 1'b0);
    for (int c = 0; c < 12; c++) begin
      cyc(0, 1, 0, 8'h5A, 1, 0);
      check($sformatf("post-rst c%0d valid", c), vector_valid, 1'b0);
      check($sformatf("post-rst c%0d inta_n", c), interrupt_acknowledge_n, 1'b1);
    end
    $display("[TB] reset mid-pulse sequence done");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
